// File: rtl/serial_sub4.sv
// Bit-serial subtractor: d = x - y, one bit per clock, LSB first, with borrow-out.
// A single full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_sub4 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         b
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    xs_q, xs_d;
    logic [W-1:0]    ys_q, ys_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    d_q, d_d;
    logic            bf_q, bf_d;
    logic            b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic xi, yi, diff, bf_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bf_q    <= 1'b0;
            b_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bf_q    <= bf_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        xi      = xs_q[0];
        yi      = ys_q[0];
        diff    = xi ^ yi ^ bf_q;
        bf_next = (~xi & yi) | (~(xi ^ yi) & bf_q);

        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        d_d     = d_q;
        bf_d    = bf_q;
        b_d     = b_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE lasts one cycle; a pending start restarts with no bubble.
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    res_d   = '0;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                bf_d  = bf_next;
                res_d = {diff, res_q[W-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    d_d     = {diff, res_q[W-1:1]};
                    b_d     = bf_next;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign d    = d_q;
    assign b    = b_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed self-checking bench for serial_sub4 (W=4).
module tb_serial_sub4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       b;

    int total = 0;
    int bad   = 0;

    serial_sub4 #(.W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .busy (busy),
        .done (done),
        .d    (d),
        .b    (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE, checking handshake timing and result.
    task automatic do_op(input logic [3:0] xv, input logic [3:0] yv,
                         input logic [3:0] ed, input logic eb, input string name);
        int n;
        x = xv;
        y = yv;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL %s latency: %0d cycles required 4", name, n);
        end
        total++;
        if (d !== ed || b !== eb || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s result: d=%h b=%b busy=%b required d=%h b=%b busy=0",
                     name, d, b, busy, ed, eb);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse: done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        x = 4'h5;
        y = 4'h2;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== 4'h0 || b !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b d=%h b=%b required all 0", busy, done, d, b);
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        do_op(4'd9, 4'd3, 4'h6, 1'b0, "sub_9_3");
        do_op(4'd3, 4'd9, 4'hA, 1'b1, "sub_3_9");
        do_op(4'd0, 4'd1, 4'hF, 1'b1, "sub_0_1");
        do_op(4'd15, 4'd15, 4'h0, 1'b0, "sub_15_15");
    endtask

    task automatic test_hold();
        do_op(4'd12, 4'd5, 4'h7, 1'b0, "hold_op");
        x = 4'h0;
        y = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (d !== 4'h7 || b !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold: d=%h b=%b busy=%b required d=7 b=0 busy=0", d, b, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] xa [3];
        logic [3:0] ya [3];
        logic [3:0] ed [3];
        logic       eb [3];
        int op;
        int last;
        int cyc;
        xa[0] = 4'd7;  ya[0] = 4'd2;  ed[0] = 4'h5; eb[0] = 1'b0;
        xa[1] = 4'd1;  ya[1] = 4'd8;  ed[1] = 4'h9; eb[1] = 1'b1;
        xa[2] = 4'd10; ya[2] = 4'd10; ed[2] = 4'h0; eb[2] = 1'b0;
        op = 0;
        last = -1;
        x = xa[0];
        y = ya[0];
        start = 1'b1;
        cyc = 0;
        while (op < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (busy === 1'b1 && done === 1'b1) begin
                total++;
                bad++;
                $display("FAIL b2b_overlap: busy=1 done=1 at cycle %0d", cyc);
            end
            if (done === 1'b1) begin
                total++;
                if (d !== ed[op] || b !== eb[op]) begin
                    bad++;
                    $display("FAIL b2b_result%0d: d=%h b=%b required d=%h b=%b",
                             op, d, b, ed[op], eb[op]);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 5) begin
                        bad++;
                        $display("FAIL b2b_spacing%0d: %0d cycles required 5", op, cyc - last);
                    end
                end
                last = cyc;
                op++;
                if (op < 3) begin
                    x = xa[op];
                    y = ya[op];
                end else begin
                    start = 1'b0;
                end
            end else begin
                x = 4'($urandom);
                y = 4'($urandom);
            end
        end
        total++;
        if (op != 3) begin
            bad++;
            $display("FAIL b2b_count: %0d ops completed required 3", op);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_ignore_mid();
        int pulses;
        x = 4'd5;
        y = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        x = 4'd1;
        y = 4'd0;
        tick();
        start = 1'b0;
        x = 4'd15;
        y = 4'd0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                pulses++;
                total++;
                if (d !== 4'hE || b !== 1'b1) begin
                    bad++;
                    $display("FAIL ignore_result: d=%h b=%b required d=e b=1", d, b);
                end
            end
            tick();
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL ignore_pulses: %0d done pulses required 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        x = 4'd12;
        y = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== 4'h0 || b !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b d=%h b=%b required all 0", busy, done, d, b);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_pulse: %0d done pulses required 0", pulses);
        end
        do_op(4'd12, 4'd2, 4'hA, 1'b0, "after_reset");
    endtask

    task automatic test_sweep();
        logic [4:0] full;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                full = {1'b0, 4'(i)} - {1'b0, 4'(j)};
                do_op(4'(i), 4'(j), full[3:0], full[4], $sformatf("sweep_%0d_%0d", i, j));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_ignore_mid();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
